life_cmd_sequencer: RTL and testbench

//  Sole driver of pe_array cmd/address/state_in. Turns button, switch and run-mode requests into legal

---
 rtl/life_pkg.sv | 19 +
 rtl/edge_pulse.sv | 26 ++
 rtl/life_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_life_cmd_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared command and sequencer state encodings for the life array
// control path.
package life_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_STEP  = 2'b01,
        CMD_WRITE = 2'b11
    } life_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_STEP,
        S_WAIT,
        S_CLEAR
    } seq_state_t;

endpackage

// File: rtl/edge_pulse.sv
// Two-flop synchroniser for an asynchronous button, followed by a
// one-cycle pulse on each synchronised rising edge.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/life_cmd_sequencer.sv
// Sole driver of the pe_array command port: arbitrates clear/write/step
// requests into single-cycle commands and counts completed generations.
module life_cmd_sequencer
    import life_pkg::*;
#(
    parameter int N_PX_BITS = 4,
    parameter int N_PY_BITS = 4,
    parameter int PERIOD    = 100_000_000,
    parameter int GEN_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_i,
    input  logic                 step_i,
    input  logic                 write_i,
    input  logic                 clear_i,
    input  logic [N_PX_BITS-1:0] wr_x_i,
    input  logic [N_PY_BITS-1:0] wr_y_i,
    input  logic                 wr_state_i,
    input  logic                 active_i,
    output logic [1:0]           cmd_o,
    output logic [N_PX_BITS-1:0] adr_x_o,
    output logic [N_PY_BITS-1:0] adr_y_o,
    output logic                 state_o,
    output logic [GEN_BITS-1:0]  gen_o,
    output logic                 busy_o
);

    localparam int SW    = N_PX_BITS + N_PY_BITS;
    localparam int CNT_W = $clog2(PERIOD);

    logic rst_meta_q, rst_sync_q;
    logic step_p, wr_p, clr_p;
    logic run_meta_q, run_q;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic pend_step_q, pend_step_d, pend_wr_q, pend_wr_d, pend_clr_q, pend_clr_d;
    logic wait_first_q, wait_first_d;
    logic [SW-1:0] sweep_q, sweep_d;
    logic [GEN_BITS-1:0] gen_q, gen_d;
    seq_state_t state_q, state_d;
    life_cmd_t cmd_q, cmd_d;
    logic [N_PX_BITS-1:0] adr_x_q, adr_x_d;
    logic [N_PY_BITS-1:0] adr_y_q, adr_y_d;
    logic st_q, st_d;
    logic tmr_hit, clr_done;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    edge_pulse u_step  (.clk(clk), .rst_n(rst_sync_q), .d_i(step_i),  .pulse_o(step_p));
    edge_pulse u_write (.clk(clk), .rst_n(rst_sync_q), .d_i(write_i), .pulse_o(wr_p));
    edge_pulse u_clear (.clk(clk), .rst_n(rst_sync_q), .d_i(clear_i), .pulse_o(clr_p));

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            run_meta_q   <= 1'b0;
            run_q        <= 1'b0;
            tmr_q        <= '0;
            pend_step_q  <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_clr_q   <= 1'b0;
            wait_first_q <= 1'b0;
            sweep_q      <= '0;
            gen_q        <= '0;
            cmd_q        <= CMD_IDLE;
            adr_x_q      <= '0;
            adr_y_q      <= '0;
            st_q         <= 1'b0;
        end else begin
            run_meta_q   <= run_i;
            run_q        <= run_meta_q;
            tmr_q        <= tmr_d;
            pend_step_q  <= pend_step_d;
            pend_wr_q    <= pend_wr_d;
            pend_clr_q   <= pend_clr_d;
            wait_first_q <= wait_first_d;
            sweep_q      <= sweep_d;
            gen_q        <= gen_d;
            cmd_q        <= cmd_d;
            adr_x_q      <= adr_x_d;
            adr_y_q      <= adr_y_d;
            st_q         <= st_d;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!active_i) begin
                    if (pend_clr_q)       state_d = S_CLEAR;
                    else if (pend_wr_q)   state_d = S_WRITE;
                    else if (pend_step_q) state_d = S_STEP;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_STEP:  state_d = S_WAIT;
            // The array raises active one cycle after the step command.
            S_WAIT:  if (!wait_first_q && !active_i) state_d = S_IDLE;
            S_CLEAR: if (sweep_q == '1) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tmr_hit      = run_q && (tmr_q == CNT_W'(PERIOD - 1));
        tmr_d        = (run_q && !tmr_hit) ? tmr_q + CNT_W'(1) : '0;
        clr_done     = (state_q == S_CLEAR) && (sweep_q == '1);
        // New pulses win over the clear-on-serve so a request is never lost.
        pend_clr_d   = (pend_clr_q & ~clr_done) | clr_p;
        pend_wr_d    = (pend_wr_q & (state_q != S_WRITE)) | wr_p;
        pend_step_d  = (pend_step_q & (state_q != S_STEP) & ~clr_done) | step_p | tmr_hit;
        wait_first_d = (state_q == S_STEP);
        sweep_d      = (state_q == S_CLEAR) ? sweep_q + SW'(1) : '0;
        gen_d        = gen_q;
        if (clr_done)
            gen_d = '0;
        else if (state_q == S_WAIT && state_d == S_IDLE)
            gen_d = gen_q + GEN_BITS'(1);
    end

    // Outputs are registered, so they are computed from the next state.
    always_comb begin
        cmd_d   = CMD_IDLE;
        adr_x_d = adr_x_q;
        adr_y_d = adr_y_q;
        st_d    = st_q;
        case (state_d)
            S_WRITE: begin
                cmd_d   = CMD_WRITE;
                adr_x_d = wr_x_i;
                adr_y_d = wr_y_i;
                st_d    = wr_state_i;
            end
            S_STEP:  cmd_d = CMD_STEP;
            S_CLEAR: begin
                cmd_d   = CMD_WRITE;
                adr_x_d = sweep_d[N_PX_BITS-1:0];
                adr_y_d = sweep_d[SW-1:N_PX_BITS];
                st_d    = 1'b0;
            end
            default: cmd_d = CMD_IDLE;
        endcase
    end

    assign cmd_o   = cmd_q;
    assign adr_x_o = adr_x_q;
    assign adr_y_o = adr_y_q;
    assign state_o = st_q;
    assign gen_o   = gen_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_life_cmd_sequencer.sv
// Directed bench for life_cmd_sequencer; a second instance with a 2-bit
// generation counter shares the stimulus to exercise counter wrap.
module tb_life_cmd_sequencer;

    localparam int PX = 4;
    localparam int PY = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run_i = 1'b0, step_i = 1'b0, write_i = 1'b0, clear_i = 1'b0;
    logic [PX-1:0] wr_x_i = '0;
    logic [PY-1:0] wr_y_i = '0;
    logic wr_state_i = 1'b0;
    logic active_i;

    logic [1:0] cmd_o, cmd_w;
    logic [PX-1:0] adr_x_o, adr_x_w;
    logic [PY-1:0] adr_y_o, adr_y_w;
    logic state_o, state_w, busy_o, busy_w;
    logic [15:0] gen_o;
    logic [1:0] gen_w;

    int n_chk = 0;
    int n_fail = 0;
    int act_len = 5;
    int act_cnt = 0;

    always #5 clk = ~clk;

    // Array model: busy for act_len cycles after it sees a step command.
    always @(posedge clk) begin
        if (cmd_o == 2'b01 && act_len > 0) act_cnt <= act_len;
        else if (act_cnt > 0)              act_cnt <= act_cnt - 1;
    end
    assign active_i = (act_cnt > 0);

    life_cmd_sequencer #(.N_PX_BITS(PX), .N_PY_BITS(PY), .PERIOD(10), .GEN_BITS(16)) dut (
        .clk(clk), .reset(reset), .run_i(run_i), .step_i(step_i), .write_i(write_i),
        .clear_i(clear_i), .wr_x_i(wr_x_i), .wr_y_i(wr_y_i), .wr_state_i(wr_state_i),
        .active_i(active_i), .cmd_o(cmd_o), .adr_x_o(adr_x_o), .adr_y_o(adr_y_o),
        .state_o(state_o), .gen_o(gen_o), .busy_o(busy_o)
    );

    life_cmd_sequencer #(.N_PX_BITS(PX), .N_PY_BITS(PY), .PERIOD(10), .GEN_BITS(2)) dut_w (
        .clk(clk), .reset(reset), .run_i(run_i), .step_i(step_i), .write_i(write_i),
        .clear_i(clear_i), .wr_x_i(wr_x_i), .wr_y_i(wr_y_i), .wr_state_i(wr_state_i),
        .active_i(active_i), .cmd_o(cmd_w), .adr_x_o(adr_x_w), .adr_y_o(adr_y_w),
        .state_o(state_w), .gen_o(gen_w), .busy_o(busy_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt, good, last, bad;

        // Reset held with buttons toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            step_i = i[0]; write_i = ~i[0]; clear_i = i[1];
        end
        chk("rst_cmd", 32'(cmd_o), 0);
        chk("rst_gen", 32'(gen_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_adr", 32'({adr_y_o, adr_x_o, state_o}), 0);
        step_i = 1'b0; write_i = 1'b0; clear_i = 1'b0;
        nxt(2);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cmd_o != 2'b00 || busy_o) cnt++;
        end
        chk("rst_release_quiet", 32'(cnt), 0);

        // Single write
        wr_x_i = 4'd3; wr_y_i = 4'd9; wr_state_i = 1'b1; write_i = 1'b1;
        nxt(3);
        chk("wr_pre", 32'(cmd_o), 0);
        nxt(1);
        chk("wr_cmd", 32'(cmd_o), 3);
        chk("wr_adr", 32'({adr_y_o, adr_x_o, state_o}), 32'({4'd9, 4'd3, 1'b1}));
        chk("wr_busy", 32'(busy_o), 1);
        write_i = 1'b0;
        nxt(1);
        chk("wr_post", 32'(cmd_o), 0);
        chk("wr_hold", 32'({adr_y_o, adr_x_o, state_o}), 32'({4'd9, 4'd3, 1'b1}));
        chk("wr_idle", 32'(busy_o), 0);

        // Step with array busy for 5 cycles, then a second press mid-wait
        step_i = 1'b1;
        nxt(3);
        chk("st_pre", 32'(cmd_o), 0);
        nxt(1);
        chk("st_cmd", 32'(cmd_o), 1);
        step_i = 1'b0;
        nxt(1);
        chk("st_after", 32'(cmd_o), 0);
        chk("st_busy", 32'(busy_o), 1);
        nxt(1);
        step_i = 1'b1;
        nxt(2);
        step_i = 1'b0;
        nxt(2);
        chk("st_wait_busy", 32'(busy_o), 1);
        chk("st_wait_gen", 32'(gen_o), 0);
        nxt(1);
        chk("st_done_busy", 32'(busy_o), 0);
        chk("st_done_gen", 32'(gen_o), 1);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (cmd_o == 2'b01) cnt++;
        end
        chk("st_second_once", 32'(cnt), 1);
        chk("st_gen2", 32'(gen_o), 2);

        // All three requests in the same cycle: clear, then write, then no step
        wr_x_i = 4'd5; wr_y_i = 4'd10; wr_state_i = 1'b1;
        step_i = 1'b1; write_i = 1'b1; clear_i = 1'b1;
        nxt(3);
        chk("pri_pre", 32'(cmd_o), 0);
        step_i = 1'b0; write_i = 1'b0; clear_i = 1'b0;
        good = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (cmd_o == 2'b11 && state_o == 1'b0 && adr_x_o == i[3:0] && adr_y_o == i[7:4])
                good++;
        end
        chk("pri_sweep", 32'(good), 256);
        nxt(1);
        chk("pri_gap", 32'(cmd_o), 0);
        nxt(1);
        chk("pri_wr", 32'({cmd_o, adr_y_o, adr_x_o, state_o}), 32'({2'b11, 4'd10, 4'd5, 1'b1}));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_o == 2'b01) cnt++;
        end
        chk("pri_no_step", 32'(cnt), 0);
        chk("pri_gen", 32'(gen_o), 0);
        chk("pri_gen_w", 32'(gen_w), 0);

        // Free-run with PERIOD=10 and array never busy
        act_len = 0;
        run_i = 1'b1;
        cnt = 0; last = -1; bad = 0; good = -1;
        for (int i = 1; i <= 55; i++) begin
            @(negedge clk);
            if (cmd_o == 2'b01) begin
                if (last >= 0 && i - last != 10) bad++;
                if (last < 0) good = i;
                last = i;
                cnt++;
            end
        end
        run_i = 1'b0;
        chk("run_count", 32'(cnt), 5);
        chk("run_first", 32'(good), 13);
        chk("run_spacing", 32'(bad), 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cmd_o == 2'b01) cnt++;
        end
        chk("run_stopped", 32'(cnt), 0);
        chk("run_gen", 32'(gen_o), 5);
        chk("run_gen_w", 32'(gen_w), 1);

        // Clear, then four steps to wrap the 2-bit counter
        clear_i = 1'b1;
        nxt(1);
        clear_i = 1'b0;
        nxt(270);
        chk("wrap_clr_gen", 32'(gen_w), 0);
        for (int k = 0; k < 4; k++) begin
            step_i = 1'b1;
            nxt(1);
            step_i = 1'b0;
            nxt(9);
            chk("wrap_gen_w", 32'(gen_w), 32'((k + 1) % 4));
            chk("wrap_gen", 32'(gen_o), 32'(k + 1));
        end

        // Reset in the middle of a clear sweep
        clear_i = 1'b1;
        nxt(1);
        clear_i = 1'b0;
        nxt(20);
        chk("clr17", 32'({cmd_o, adr_y_o, adr_x_o}), 32'({2'b11, 4'd1, 4'd1}));
        reset = 1'b0;
        #1;
        chk("mid_rst_cmd", 32'(cmd_o), 0);
        chk("mid_rst_state", 32'({busy_o, gen_o, adr_y_o, adr_x_o}), 0);
        nxt(3);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (cmd_o != 2'b00 || busy_o) cnt++;
        end
        chk("mid_rst_quiet", 32'(cnt), 0);
        clear_i = 1'b1;
        nxt(1);
        clear_i = 1'b0;
        nxt(3);
        chk("clr_restart", 32'({cmd_o, adr_y_o, adr_x_o}), 32'({2'b11, 4'd0, 4'd0}));
        nxt(260);
        chk("clr_restart_done", 32'({busy_o, cmd_o}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
